// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter
// Description : Two-master arbiter for the 8-bit register bus (SPI path and
//               packet engine). Define REG_ARB_SPI_PRIO_EN for fixed port-0
//               priority; otherwise ties are resolved round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int            AW       = 7,
  parameter int            DW       = 8,
  parameter int            RD_LAT   = 1,
  parameter logic [AW-1:0] ADDR_MAX = 7'h1F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic          bus_re,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0]    C_CNT_LAST = 3'(RD_LAT - 1);
  localparam logic [DW-1:0] C_ERR_DATA = {DW{1'b1}};

  state_t        r_state, w_state_nxt;
  logic          w_req0, w_req1, w_any, w_pick, w_addr_ok;
  logic          r_owner, r_we, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_cnt;
  logic          r_ack0, r_ack1, r_err0, r_err1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic          r_bus_we, r_bus_re;

  // A master still holds req during its ack cycle; mask it so it is not re-granted.
  assign w_req0    = req0 & ~r_ack0;
  assign w_req1    = req1 & ~r_ack1;
  assign w_any     = w_req0 | w_req1;
  assign w_addr_ok = (r_addr <= ADDR_MAX);

`ifdef REG_ARB_SPI_PRIO_EN
  assign w_pick = ~w_req0;
`else
  logic w_tie, r_tie, r_last_winner;

  assign w_tie  = w_req0 & w_req1;
  assign w_pick = w_tie ? ~r_last_winner : w_req1;

  // Only contested grants move the pointer, so the loser of a tie wins the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tie         <= 1'b0;
      r_last_winner <= 1'b1;
    end else begin
      if (r_state == S_IDLE && w_any) r_tie <= w_tie;
      if (r_state == S_DONE && r_tie) r_last_winner <= r_owner;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = (r_we || !w_addr_ok) ? S_DONE : S_RDWAIT;
      S_RDWAIT: if (r_cnt == C_CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_bus_we <= 1'b0;
      r_bus_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_we    <= w_pick ? we1    : we0;
            r_addr  <= w_pick ? addr1  : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
            r_err   <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (w_addr_ok) begin
            r_bus_addr <= r_addr;
            r_bus_we   <= r_we;
            r_bus_re   <= ~r_we;
            if (r_we) r_bus_wdata <= r_wdata;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_RDWAIT: r_cnt <= r_cnt + 3'd1;
        S_DONE: begin
          // Read data is valid on the bus exactly in the DONE cycle.
          if (r_owner) begin
            r_ack1 <= 1'b1;
            r_err1 <= r_err;
            if (r_err)      r_rdata1 <= C_ERR_DATA;
            else if (!r_we) r_rdata1 <= bus_rdata;
          end else begin
            r_ack0 <= 1'b1;
            r_err0 <= r_err;
            if (r_err)      r_rdata0 <= C_ERR_DATA;
            else if (!r_we) r_rdata0 <= bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule
`default_nettype wire
